// File: rtl/gcd_binary.sv
// Binary (Stein) GCD engine: one micro-step per clock, no divider or multiplier.
// Registered result plus coprime and zero-operand flags; done is a one-cycle Moore pulse.
module gcd_binary #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done,
  output logic             coprime,
  output logic             zero_in
);

  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_EVEN,
    S_STRIP,
    S_SUB,
    S_FINAL,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             coprime_q, coprime_d;
  logic             zero_in_q, zero_in_d;
  logic [WIDTH-1:0] final_val;

  // Restoring the common power of two; the true GCD never exceeds the operands, so it fits.
  assign final_val = a_q << k_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    res_d     = res_q;
    coprime_d = coprime_q;
    zero_in_d = zero_in_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          k_d     = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (a_q == '0 || b_q == '0) begin
          res_d     = a_q | b_q;
          zero_in_d = 1'b1;
          coprime_d = ((a_q | b_q) == WIDTH'(1));
          state_d   = S_DONE;
        end else begin
          zero_in_d = 1'b0;
          state_d   = S_EVEN;
        end
      end
      S_EVEN: begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = S_STRIP;
        end
      end
      S_STRIP: begin
        // Only one operand is halved per cycle; a takes precedence.
        if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else begin
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        if (a_q == b_q) begin
          state_d = S_FINAL;
        end else if (a_q > b_q) begin
          a_d     = a_q - b_q;
          state_d = S_STRIP;
        end else begin
          b_d     = b_q - a_q;
          state_d = S_STRIP;
        end
      end
      S_FINAL: begin
        res_d     = final_val;
        coprime_d = (final_val == WIDTH'(1));
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      res_q     <= '0;
      coprime_q <= 1'b0;
      zero_in_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      k_q       <= k_d;
      res_q     <= res_d;
      coprime_q <= coprime_d;
      zero_in_q <= zero_in_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign res     = res_q;
  assign coprime = coprime_q;
  assign zero_in = zero_in_q;

endmodule

// File: tb/tb_gcd_binary.sv
// Self-checking bench for gcd_binary: directed corner cases, reset abort and
// randomised requests with start/operand churn, scored against a Euclid reference.
module tb_gcd_binary;

  localparam int W     = 8;
  localparam int LIMIT = 8 * W + 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] res;
  logic         busy;
  logic         done;
  logic         coprime;
  logic         zero_in;

  int n_vec     = 0;
  int n_err     = 0;
  int done_cnt  = 0;
  int exp_dones = 0;

  gcd_binary #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (a_in),
    .B       (b_in),
    .res     (res),
    .busy    (busy),
    .done    (done),
    .coprime (coprime),
    .zero_in (zero_in)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Euclid's algorithm: deliberately a different method from the hardware.
  function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic run_req(input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit churn, input bit tight);
    int          cyc;
    bit          seen;
    int unsigned g;
    cyc = 0;
    while (busy && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_before_start", busy, 0);
    start = 1'b1;
    a_in  = x;
    b_in  = y;
    @(posedge clk);
    #1;
    exp_dones++;
    start = 1'b0;
    if (churn) begin
      start = 1'($urandom_range(0, 1));
      a_in  = W'($urandom);
      b_in  = W'($urandom);
    end
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      else if (churn) begin
        start = 1'($urandom_range(0, 1));
        a_in  = W'($urandom);
        b_in  = W'($urandom);
      end
    end
    start = 1'b0;
    g = ref_gcd(32'(x), 32'(y));
    check("done_seen", seen, 1);
    check("res", res, g);
    check("coprime", coprime, (g == 1));
    check("zero_in", zero_in, (x == 0 || y == 0));
    if (x == 0 || y == 0) check("zero_latency", cyc, 2);
    else if (tight) check("latency_bound", (cyc <= 4 * W + 4), 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("res_hold", res, g);
  endtask

  initial begin
    int cyc;
    int snap;
    logic [W-1:0] x;
    logic [W-1:0] y;

    // Reset with start asserted: the request must be ignored.
    rst   = 1'b1;
    start = 1'b1;
    a_in  = W'(12);
    b_in  = W'(8);
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", res, 0);
    check("rst_coprime", coprime, 0);
    check("rst_zero_in", zero_in, 0);

    // 12,8 with start held high: re-accepted only once back in IDLE.
    start = 1'b1;
    a_in  = W'(12);
    b_in  = W'(8);
    cyc   = 0;
    while (!done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check("held_done_seen", done, 1);
    check("held_res", res, 4);
    check("held_coprime", coprime, 0);
    check("held_zero_in", zero_in, 0);
    @(negedge clk);
    check("held_idle_gap", busy, 0);
    @(negedge clk);
    check("held_reaccept", busy, 1);
    start     = 1'b0;
    exp_dones += 2;
    cyc = 0;
    while (busy && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check("held_second_res", res, 4);

    // Directed corner cases.
    run_req(W'(48),  W'(180), 1'b0, 1'b1);
    run_req(W'(9),   W'(4),   1'b0, 1'b1);
    run_req(W'(0),   W'(0),   1'b0, 1'b1);
    run_req(W'(15),  W'(0),   1'b0, 1'b1);
    run_req(W'(7),   W'(7),   1'b0, 1'b1);
    run_req(W'(128), W'(128), 1'b0, 1'b1);
    run_req(W'(255), W'(85),  1'b0, 1'b1);

    // Abort 200,75 with rst in the third busy cycle.
    snap  = done_cnt;
    start = 1'b1;
    a_in  = W'(200);
    b_in  = W'(75);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_res", res, 0);
    check("abort_coprime", coprime, 0);
    repeat (6) @(negedge clk);
    check("abort_no_pulse", done_cnt, snap);
    run_req(W'(200), W'(75), 1'b0, 1'b1);

    // Random requests with start and operands churning while busy.
    for (int i = 0; i < 400; i++) begin
      x = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      y = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      run_req(x, y, 1'b1, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("done_pulse_count", done_cnt, exp_dones);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
